// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage
//
// Instruction-fetch stage. It issues one word request at a time to the
// instruction memory and buffers returned words in a 2-entry FIFO of
// {pc, instr}. The FIFO head goes to decode with zero latency. A redirect
// flushes all fetched work and restarts fetching at redirect_pc. If a
// request is still outstanding at that moment, the request is held until
// it is acknowledged, and its data is discarded.
//
// Optional feature (compile-time macro FETCH_ALIGN_CHECK_EN):
//   defined   - a redirect to an address with bits [1:0] != 0 flushes the
//               FIFO and enters FAULT. fetch_fault is asserted and stays
//               asserted, and no requests are issued until an aligned
//               redirect or a reset.
//   undefined - redirect_pc[1:0] is forced to 2'b00 and fetch_fault is 0.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   imem_req     out  memory request, held until imem_ack
//   imem_addr    out  word address of the request, stable while imem_req
//   imem_ack     in   request accepted, imem_rdata valid this cycle
//   imem_rdata   in   instruction word
//   redirect     in   branch/jump taken, discard fetched work
//   redirect_pc  in   new fetch address
//   if_valid     out  head entry valid toward decode
//   if_ready     in   decode accepts the head entry
//   if_instr     out  head instruction
//   if_pc        out  head instruction address
//   fetch_fault  out  misaligned redirect detected (sticky)
// ---------------------------------------------------------------------------
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IDLE  = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_FAULT = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;   // address of current/next request
    logic [31:0] redir_pc_q, redir_pc_d;   // target held while draining a stale request
    logic        discard_q, discard_d;     // outstanding request belongs to a flushed path
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] pc_mem_q    [2];
    logic [31:0] instr_mem_q [2];
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
    logic        redir_fault_q, redir_fault_d;  // drained redirect target was misaligned
`endif

    logic        req_int;
    logic        valid_int;
    logic        push;
    logic        pop;
    logic        redir_bad;
    logic [31:0] redir_tgt;

    assign req_int   = (state_q == ST_FETCH);
    assign valid_int = (count_q != 2'd0);

    // A redirect flushes the FIFO, so a pop or push in that same cycle is dropped.
    assign pop  = valid_int && if_ready && !redirect;
    assign push = req_int && imem_ack && !discard_q && !redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad = (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = redirect_pc;
`else
    assign redir_bad = 1'b0;
    assign redir_tgt = redirect_pc & ~32'h0000_0003;
`endif

    // Next-state and control
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        discard_d  = discard_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d       = fault_q;
        redir_fault_d = redir_fault_q;
`endif

        if (redirect) begin
            if (req_int && !imem_ack) begin
                // The memory still owes us a word. Keep req/addr steady,
                // drop the word when it arrives, and restart afterwards.
                discard_d  = 1'b1;
                redir_pc_d = redir_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
                fault_d       = redir_bad;
                redir_fault_d = redir_bad;
`endif
            end else begin
                // Nothing left in flight (any ack this cycle is thrown away).
                discard_d  = 1'b0;
                fetch_pc_d = redir_tgt;
                state_d    = ST_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                fault_d       = redir_bad;
                redir_fault_d = 1'b0;
                if (redir_bad) begin
                    state_d = ST_FAULT;
                end
`endif
            end
        end else if (req_int && imem_ack) begin
            if (discard_q) begin
                discard_d  = 1'b0;
                fetch_pc_d = redir_pc_q;
                state_d    = ST_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                redir_fault_d = 1'b0;
                if (redir_fault_q) begin
                    state_d = ST_FAULT;
                end
`endif
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                state_d    = (count_d == 2'd2) ? ST_IDLE : ST_FETCH;
            end
        end else if (state_q == ST_IDLE && pop) begin
            state_d = ST_FETCH;
        end
    end

    // FIFO bookkeeping
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d = count_q + 2'(push) - 2'(pop);
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
            redir_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= fault_d;
            redir_fault_q <= redir_fault_d;
`endif
        end
    end

    // Buffer storage is not reset. The count decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Outputs are forced to their idle values while reset is asserted.
    assign imem_req  = !reset && req_int;
    assign imem_addr = reset ? RESET_PC : fetch_pc_q;
    assign if_valid  = !reset && valid_int;
    assign if_pc     = if_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign if_instr  = if_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = !reset && fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ifetch_stage
//
// Directed bench for ifetch_stage. The memory model returns a word derived
// from the address. A per-cycle vector table covers streaming, back-pressure,
// redirect, address wrap and misaligned redirect. Hand-written sequences
// cover a delayed acknowledge, back-to-back redirects and a reset issued in
// the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    logic        zero_wait;
    logic        man_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) + 32'h1000_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = zero_wait ? imem_req : man_ack;

    ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .fetch_fault (fetch_fault)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc, input logic e_fault);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy, input logic ack);
        redirect    = redir;
        redirect_pc = rpc;
        if_ready    = rdy;
        man_ack     = ack;
    endtask

    // Reset is held for two clock edges. The task returns just after a
    // falling edge with reset low, so the next check sees the first cycle
    // after reset.
    task automatic do_reset(input logic check_it);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        if (check_it) begin
            chk("rst_req",   32'(imem_req),    32'h0);
            chk("rst_addr",  imem_addr,        32'h0);
            chk("rst_valid", 32'(if_valid),    32'h0);
            chk("rst_instr", if_instr,         32'h0);
            chk("rst_pc",    if_pc,            32'h0);
            chk("rst_fault", 32'(fetch_fault), 32'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        zero_wait = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Table: one row per cycle, starting at the first cycle after reset.
        // Columns: redirect, redirect_pc, if_ready, then the expected
        // imem_req, imem_addr, if_valid, if_pc and fetch_fault.
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0,         0)); // c0
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'h0000_0004, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_000C, 1, 32'h0000_0008, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1, 32'h0000_0010, 1, 32'h0000_000C, 0)); // stall
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_000C, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_000C, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_000C, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_000C, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_000C, 0)); // release
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0014, 1, 32'h0000_0010, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0018, 1, 32'h0000_0014, 0));
        vecs.push_back(mk(1, 32'h0000_0040, 1, 1, 32'h0000_001C, 1, 32'h0000_0018, 0)); // redirect + ack
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0040, 0, 32'h0,         0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0044, 1, 32'h0000_0040, 0));
        vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 1, 32'h0000_0048, 1, 32'h0000_0044, 0)); // wrap
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0,         0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(1, 32'h0000_0102, 1, 1, 32'h0000_0008, 1, 32'h0000_0004, 0)); // misaligned
`ifdef FETCH_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1));
        vecs.push_back(mk(1, 32'h0000_0200, 1, 0, 32'h0,         0, 32'h0,         1));
`else
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0100, 0, 32'h0,         0));
        vecs.push_back(mk(1, 32'h0000_0200, 1, 1, 32'h0000_0104, 1, 32'h0000_0100, 0));
`endif
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0200, 0, 32'h0,         0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0204, 1, 32'h0000_0200, 0));

        do_reset(1'b1);
        zero_wait = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, 1'b0);
            #1;
            $display("vec %0d: redir=%0b rpc=%h rdy=%0b | req=%0b addr=%h valid=%0b pc=%h fault=%0b",
                     i, vecs[i].redir, vecs[i].rpc, vecs[i].rdy,
                     imem_req, imem_addr, if_valid, if_pc, fetch_fault);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].e_val));
            if (vecs[i].e_val) begin
                chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_instr", i), if_instr, mem_word(vecs[i].e_pc));
            end
            chk($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].e_fault));
            @(negedge clk);
        end

        // Ack delayed three cycles with a redirect in the second cycle:
        // the stale word is dropped and fetch resumes at 0x100.
        do_reset(1'b0);
        zero_wait = 1'b0;
        drive(0, 32'h0, 1, 0); #1;
        chk("dly_s0_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        drive(1, 32'h0000_0100, 1, 0); #1;
        chk("dly_s1_addr", imem_addr, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 0); #1;
        chk("dly_s2_req", 32'(imem_req), 32'h1);
        chk("dly_s2_addr_held", imem_addr, 32'h0);
        chk("dly_s2_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 1); #1;
        chk("dly_s3_addr_held", imem_addr, 32'h0);
        $display("seq delayed-ack: stale ack at addr %h", imem_addr);
        @(negedge clk);
        drive(0, 32'h0, 1, 0); #1;
        chk("dly_s4_valid", 32'(if_valid), 32'h0);
        chk("dly_s4_req", 32'(imem_req), 32'h1);
        chk("dly_s4_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        drive(0, 32'h0, 1, 1); #1;
        @(negedge clk);
        drive(0, 32'h0, 1, 0); #1;
        chk("dly_s6_valid", 32'(if_valid), 32'h1);
        chk("dly_s6_pc", if_pc, 32'h0000_0100);
        chk("dly_s6_instr", if_instr, mem_word(32'h0000_0100));
        $display("seq delayed-ack: if_pc=%h", if_pc);

        // Two redirects while a request is outstanding: the last one wins.
        do_reset(1'b0);
        zero_wait = 1'b0;
        drive(1, 32'h0000_0300, 1, 0); #1;
        @(negedge clk);
        drive(1, 32'h0000_0500, 1, 0); #1;
        chk("b2b_s1_addr_held", imem_addr, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 1); #1;
        chk("b2b_s2_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 1); #1;
        chk("b2b_s3_addr", imem_addr, 32'h0000_0500);
        chk("b2b_s3_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 0); #1;
        chk("b2b_s4_valid", 32'(if_valid), 32'h1);
        chk("b2b_s4_pc", if_pc, 32'h0000_0500);
        $display("seq back-to-back: if_pc=%h", if_pc);

        // Reset while a discarded request is outstanding: the stale request
        // and the discard flag are both abandoned.
        do_reset(1'b0);
        zero_wait = 1'b0;
        drive(1, 32'h0000_0080, 1, 0); #1;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 32'h0, 1, 1); #1;
        chk("rmid_req", 32'(imem_req), 32'h0);
        chk("rmid_addr", imem_addr, 32'h0);
        chk("rmid_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 32'h0, 1, 1); #1;
        chk("rpost_req", 32'(imem_req), 32'h1);
        chk("rpost_addr", imem_addr, 32'h0);
        chk("rpost_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 0); #1;
        chk("rpost_valid2", 32'(if_valid), 32'h1);
        chk("rpost_pc", if_pc, 32'h0);
        chk("rpost_next_addr", imem_addr, 32'h0000_0004);
        $display("seq reset-mid: if_pc=%h next addr=%h", if_pc, imem_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request, held until acknowledged.
REQ-005 SHALL have port imem_addr  output  32  fetch word address, stable while imem_req high.
REQ-006 SHALL have port imem_ack  input  1  request accepted and read data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, sampled only when imem_req && imem_ack.
REQ-008 SHALL have port redirect  input  1  branch/jump taken, discard all fetched work.
REQ-009 SHALL have port redirect_pc  input  32  new fetch address when redirect high.
REQ-010 SHALL have port if_valid  output  1  if_instr/if_pc valid toward decode.
REQ-011 SHALL have port if_ready  input  1  decode accepts; transfer when if_valid && if_ready.
REQ-012 SHALL have port if_instr  output  32  head-of-buffer instruction.
REQ-013 SHALL have port if_pc  output  32  address of if_instr.
REQ-014 SHALL have port fetch_fault  output  1  misaligned redirect detected (see Configuration).

Function
REQ-015 SHALL contain a 2-entry FIFO of {pc, instr}; if_valid = (count != 0); head presented with zero latency.
REQ-016 SHALL run FSM FETCH (req high), IDLE (req low, FIFO full), FAULT (req low); at most one outstanding request.
REQ-017 SHALL raise imem_req in a cycle only if count < 2 at transaction start, then hold req and imem_addr unchanged until imem_ack.
REQ-018 SHALL accept imem_ack in the same cycle req rises (zero wait) or any later cycle.
REQ-019 On non-discarded ack, SHALL push {imem_addr, imem_rdata} and set fetch PC = imem_addr + 4, modulo 2^32 (wrap 32'hFFFF_FFFC -> 0).
REQ-020 After a push making count = 2, SHALL go IDLE; SHALL return to FETCH the cycle after a pop.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, preserving order.
REQ-022 Redirect SHALL flush the FIFO (if_valid low next cycle) and load fetch PC = redirect_pc; a pop in the same cycle is ignored.
REQ-023 If a request is outstanding at redirect, SHALL keep req/addr held until ack, discard that data, then request redirect_pc; ack in the redirect cycle itself is discarded.
REQ-024 Redirect with no request outstanding SHALL put redirect_pc on imem_addr with req high the next cycle.
REQ-025 Back-to-back redirects: last redirect_pc SHALL win.
REQ-026 Latency: zero-wait memory, redirect at cycle N -> req at N+1, if_valid at N+2.

Reset
REQ-027 While reset high: imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, fetch_fault 0, FIFO empty, discard flag clear; imem_ack and redirect ignored.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; first cycle after reset SHALL assert imem_req at RESET_PC.

Configuration
REQ-029 With FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 SHALL flush, enter FAULT, assert fetch_fault next cycle, sticky, no requests until an aligned redirect or reset.
REQ-030 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 2'b00; fetch_fault tied 0; no FAULT state.

Verification
REQ-031 Reset release, zero-wait memory, if_ready=1 -> addresses 0,4,8,... one per cycle; if_pc/if_instr match memory.
REQ-032 if_ready=0 for 5 cycles -> exactly two entries buffered, imem_req low, no data lost; release yields in-order pcs.
REQ-033 imem_ack delayed 3 cycles with redirect to 32'h0000_0100 at cycle 1 -> stale word discarded; next if_pc = 32'h100.
REQ-034 Redirect and ack in same cycle -> acked word never appears on if_instr; next fetch at redirect_pc.
REQ-035 Redirect to 32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Redirect to 32'h0000_0102 -> with FETCH_ALIGN_CHECK_EN fetch_fault=1, imem_req=0; without, next fetch at 32'h100.
